// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller with a fixed-latency request/response handshake.
// One request in flight at a time; responses are held until the CPU consumes them.
module data_mem_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_read;
    logic              cap_write;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              accept;
    logic              enter_resp;
    logic              cmd_read;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              legal_read;
    logic              legal_write;
    logic              mem_we;

    assign accept = req_valid && req_ready;

    // With zero wait states the response is formed on the acceptance edge itself,
    // so the command comes straight from the ports rather than the capture registers.
    always_comb begin
        cmd_read  = cap_read;
        cmd_write = cap_write;
        cmd_addr  = cap_addr;
        cmd_wdata = cap_wdata;
        if (state == IDLE) begin
            cmd_read  = mem_read;
            cmd_write = mem_write;
            cmd_addr  = addr;
            cmd_wdata = wdata;
        end
    end

    assign enter_resp  = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                         ((state == WAIT) && (cnt == 4'd1));
    assign legal_read  = cmd_read && !cmd_write;
    assign legal_write = !cmd_read && cmd_write;
    assign mem_we      = rst && enter_resp && legal_write;

    // NOTE: the storage array has no reset; only the control path is cleared, so
    // contents survive a reset and an aborted write simply never reaches mem_we.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cmd_addr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_read  <= 1'b0;
            cap_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_addr  <= addr;
                        cap_wdata <= wdata;
                        cap_read  <= mem_read;
                        cap_write <= mem_write;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rdata     <= '0;
                        err       <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 4'd0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase

            // Response payload is latched once, on the edge entering RESP, and then held.
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rdata     <= legal_read ? mem[cmd_addr] : '0;
                err       <= !(legal_read || legal_write);
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a vector table on a 2-wait-state instance,
// plus hand sequences for stalls, resets mid-transaction, throughput and zero wait states.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid2, req_valid0;
    logic        mem_read, mem_write;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        rsp_ready;

    logic        req_ready2, rsp_valid2, err2;
    logic [15:0] rdata2;
    logic        req_ready0, rsp_valid0, err0;
    logic [15:0] rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rdata(rdata2), .err(err2)
    );

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rdata(rdata0), .err(err0)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [7:0]  a;
        logic [15:0] wd;
        logic [15:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rv(input bit sel0);
        return sel0 ? rsp_valid0 : rsp_valid2;
    endfunction

    function automatic logic rr(input bit sel0);
        return sel0 ? req_ready0 : req_ready2;
    endfunction

    // Full transaction; called at a negedge with the chosen DUT idle, returns at a negedge.
    task automatic txn(input bit sel0, input bit rd, input bit wr, input logic [7:0] a,
                       input logic [15:0] wd, input logic [15:0] exp_rdata, input bit exp_err,
                       input string name);
        int lat;
        int exp_lat;
        exp_lat = sel0 ? 1 : 3;
        check({name, " req_ready idle"}, 32'(rr(sel0)), 32'd1);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        if (sel0) req_valid0 = 1'b1; else req_valid2 = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        lat = 1;
        req_valid0 = 1'b0;
        req_valid2 = 1'b0;
        mem_read   = ~rd;
        addr       = ~a;
        wdata      = ~wd;
        while (!rv(sel0) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " rsp_valid"}, 32'(rv(sel0)), 32'd1);
        check({name, " rdata"}, 32'(sel0 ? rdata0 : rdata2), 32'(exp_rdata));
        check({name, " err"}, 32'(sel0 ? err0 : err2), 32'(exp_err));
        check({name, " req_ready busy"}, 32'(rr(sel0)), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, " rsp_valid drop"}, 32'(rv(sel0)), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{0, 1, 8'h12, 16'hBEEF, 16'h0000, 0};
        vecs[1]  = '{1, 0, 8'h12, 16'h0000, 16'hBEEF, 0};
        vecs[2]  = '{1, 1, 8'h12, 16'h0000, 16'h0000, 1};
        vecs[3]  = '{1, 0, 8'h12, 16'h0000, 16'hBEEF, 0};
        vecs[4]  = '{0, 0, 8'h12, 16'h7777, 16'h0000, 1};
        vecs[5]  = '{0, 1, 8'h20, 16'h5555, 16'h0000, 0};
        vecs[6]  = '{0, 1, 8'hFF, 16'hA5A5, 16'h0000, 0};
        vecs[7]  = '{0, 1, 8'h00, 16'h0F0F, 16'h0000, 0};
        vecs[8]  = '{1, 0, 8'hFF, 16'h0000, 16'hA5A5, 0};
        vecs[9]  = '{1, 0, 8'h00, 16'h0000, 16'h0F0F, 0};
        vecs[10] = '{1, 0, 8'h12, 16'h1234, 16'hBEEF, 0};

        rst = 1'b0;
        req_valid2 = 1'b0;
        req_valid0 = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        addr = '0;
        wdata = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready2), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid2), 32'd0);
        check("reset rdata", 32'(rdata2), 32'd0);
        check("reset err", 32'(err2), 32'd0);
        check("reset state", 32'(dut.state), 32'd0);
        check("reset cnt", 32'(dut.cnt), 32'd0);
        check("reset rsp_valid wc0", 32'(rsp_valid0), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            txn(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd,
                vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Stall in RESP for 5 cycles while a conflicting write is offered.
        mem_read = 1'b1; mem_write = 1'b0; addr = 8'h12; wdata = 16'h0;
        req_valid2 = 1'b1;
        @(negedge clk);
        req_valid2 = 1'b0;
        repeat (2) @(negedge clk);
        check("stall enter rsp_valid", 32'(rsp_valid2), 32'd1);
        mem_read = 1'b0; mem_write = 1'b1; addr = 8'h12; wdata = 16'h1111;
        req_valid2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d rsp_valid", k), 32'(rsp_valid2), 32'd1);
            check($sformatf("stall%0d rdata", k), 32'(rdata2), 32'hBEEF);
            check($sformatf("stall%0d req_ready", k), 32'(req_ready2), 32'd0);
        end
        req_valid2 = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("stall release rsp_valid", 32'(rsp_valid2), 32'd0);
        txn(1'b0, 1'b1, 1'b0, 8'h12, 16'h0, 16'hBEEF, 1'b0, "after stall");

        // Reset while a write is waiting must not commit it.
        mem_read = 1'b0; mem_write = 1'b1; addr = 8'h20; wdata = 16'hAAAA;
        req_valid2 = 1'b1;
        @(negedge clk);
        req_valid2 = 1'b0;
        check("abort in WAIT", 32'(dut.state), 32'd1);
        rst = 1'b0;
        #1;
        check("abort req_ready", 32'(req_ready2), 32'd1);
        check("abort rsp_valid", 32'(rsp_valid2), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("abort quiet%0d", k), 32'(rsp_valid2), 32'd0);
        end
        txn(1'b0, 1'b1, 1'b0, 8'h20, 16'h0, 16'h5555, 1'b0, "abort readback");

        // Asynchronous reset in RESP, between clock edges.
        mem_read = 1'b1; mem_write = 1'b0; addr = 8'h12;
        req_valid2 = 1'b1;
        @(negedge clk);
        req_valid2 = 1'b0;
        repeat (2) @(negedge clk);
        check("async pre rsp_valid", 32'(rsp_valid2), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async rsp_valid", 32'(rsp_valid2), 32'd0);
        check("async req_ready", 32'(req_ready2), 32'd1);
        check("async rdata", 32'(rdata2), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("async quiet%0d", k), 32'(rsp_valid2), 32'd0);
        end

        // Back-to-back reads with ready always high: one accept per 4 cycles.
        begin
            int accepts;
            accepts = 0;
            mem_read = 1'b1; mem_write = 1'b0; addr = 8'h12;
            req_valid2 = 1'b1;
            rsp_ready = 1'b1;
            for (int k = 0; k < 12; k++) begin
                if (req_ready2) accepts++;
                @(negedge clk);
            end
            req_valid2 = 1'b0;
            rsp_ready = 1'b0;
            check("throughput accepts", 32'(accepts), 32'd3);
            check("throughput idle", 32'(req_ready2), 32'd1);
        end

        // Zero wait states.
        txn(1'b1, 1'b0, 1'b1, 8'h05, 16'h1234, 16'h0000, 1'b0, "wc0 write");
        txn(1'b1, 1'b1, 1'b0, 8'h05, 16'h0000, 16'h1234, 1'b0, "wc0 read");
        txn(1'b1, 1'b1, 1'b1, 8'h05, 16'hFFFF, 16'h0000, 1'b1, "wc0 illegal");
        txn(1'b1, 1'b1, 1'b0, 8'h05, 16'h0000, 16'h1234, 1'b0, "wc0 reread");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
